// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state encoding.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake, run controls and status of the countdown timer.
interface countdown_timer_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_value;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, load_value, pause, abort,
        input  load_ready, count, busy, done
    );

    modport slave (
        input  load_valid, load_value, pause, abort,
        output load_ready, count, busy, done
    );
endinterface

// File: rtl/countdown_timer_prescaler.sv
// Divides enabled clk cycles by PRESCALE; tick marks the last cycle of each period.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(PRESCALE) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    // With PRESCALE==1 the counter sits at 0, so tick degenerates to en.
    assign tick = en && (cnt_q == CW'(PRESCALE - 1));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting timer with pause/abort and a one-cycle done pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic operation from a latched reload value.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             accept;
    logic             presc_en;
    logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    assign accept   = bus.load_valid && (state_q == IDLE);
    // Abort outranks a coincident tick, so the prescaler does not fire on an abort cycle.
    assign presc_en = (state_q == RUN) && !bus.abort;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en),
        .clr   (accept),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    count_d = bus.load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = bus.load_value;
`endif
                    if (bus.load_value == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    // A tick coinciding with pause is still taken; the freeze starts next cycle.
                    state_d = bus.pause ? PAUSED : RUN;
                    if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            count_d = reload_q;
`else
                            count_d = '0;
                            state_d = IDLE;
`endif
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
            end
            PAUSED: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (!bus.pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.busy       = (state_q == RUN) || (state_q == PAUSED);
    assign bus.count      = count_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: stimulus queues expected status per cycle, a negedge monitor compares.
// Two instances share clk/reset: u1 with PRESCALE=1 and u3 with PRESCALE=3.
module tb_countdown_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int         cyc;
        int         sel;
        logic [6:0] obs;
        string      name;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    exp_t exp_q[$];
    int   done1_q[$];
    int   done3_q[$];

    countdown_timer_if #(.WIDTH(4)) bus1 ();
    countdown_timer_if #(.WIDTH(4)) bus3 ();

    countdown_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    countdown_timer #(.WIDTH(4), .PRESCALE(3)) u3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected status word is {count, done, busy, load_ready}.
    task automatic push(input int sel, input int c, input logic [3:0] cnt,
                        input logic dn, input logic bsy, input logic rdy, input string nm);
        exp_t e;
        e.cyc  = c;
        e.sel  = sel;
        e.obs  = {cnt, dn, bsy, rdy};
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic push_done(input int sel, input int c);
        if (sel == 1) done1_q.push_back(c);
        else          done3_q.push_back(c);
    endtask

    // One full run of N from accept cycle k: count N - j/P, then the done cycle.
    task automatic push_run(input int sel, input int k, input int n, input int p, input string nm);
        int d;
        for (int j = 0; j < n * p; j++) begin
            push(sel, k + j, 4'(n - j / p), 1'b0, 1'b1, 1'b0, nm);
        end
        d = k + n * p;
        push(sel, d, AUTO ? 4'(n) : 4'd0, 1'b1, AUTO, !AUTO, {nm, "_done"});
        push_done(sel, d);
    endtask

    task automatic load(input int sel, input logic [3:0] v, output int k);
        if (sel == 1) begin
            bus1.load_valid = 1'b1;
            bus1.load_value = v;
        end else begin
            bus3.load_valid = 1'b1;
            bus3.load_value = v;
        end
        step(1);
        k = cyc;
        bus1.load_valid = 1'b0;
        bus3.load_valid = 1'b0;
    endtask

    task automatic set_abort(input int sel, input logic v);
        if (sel == 1) bus1.abort = v;
        else          bus3.abort = v;
    endtask

    // Monitor: compares scheduled status words and times every done pulse.
    always @(negedge clk) begin
        logic [6:0] o1, o3;
        exp_t       e;
        int         want;
        o1 = {bus1.count, bus1.done, bus1.busy, bus1.load_ready};
        o3 = {bus3.count, bus3.done, bus3.busy, bus3.load_ready};
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) check({e.name, "_stale"}, cyc, e.cyc);
            else              check(e.name, (e.sel == 1) ? {25'd0, o1} : {25'd0, o3}, {25'd0, e.obs});
        end
        if (bus1.done === 1'b1) begin
            want = (done1_q.size() > 0) ? done1_q.pop_front() : -1;
            check("u1_done_time", cyc, want);
        end
        if (bus3.done === 1'b1) begin
            want = (done3_q.size() > 0) ? done3_q.pop_front() : -1;
            check("u3_done_time", cyc, want);
        end
    end

    initial begin
        int k;
        bus1.load_valid = 1'b1; bus1.load_value = 4'd5; bus1.pause = 1'b0; bus1.abort = 1'b0;
        bus3.load_valid = 1'b1; bus3.load_value = 4'd5; bus3.pause = 1'b0; bus3.abort = 1'b0;

        // Reset overrides a pending load.
        step(2);
        push(1, cyc, 4'd0, 1'b0, 1'b0, 1'b1, "u1_reset");
        push(3, cyc, 4'd0, 1'b0, 1'b0, 1'b1, "u3_reset");
        push(1, cyc + 1, 4'd0, 1'b0, 1'b0, 1'b1, "u1_no_accept");
        reset = 1'b0;
        bus1.load_valid = 1'b0;
        bus3.load_valid = 1'b0;
        step(2);

        // PRESCALE=1, load 5: 5,4,3,2,1 then done.
        load(1, 4'd5, k);
        push_run(1, k, 5, 1, "u1_load5");
        step(5);
        set_abort(1, 1'b1);
        push(1, k + 6, AUTO ? 4'd5 : 4'd0, 1'b0, 1'b0, 1'b1, "u1_load5_after");
        step(1);
        set_abort(1, 1'b0);
        step(1);

        // PRESCALE=3, load 2: done six cycles after accept.
        load(3, 4'd2, k);
        push_run(3, k, 2, 3, "u3_load2");
        step(6);
        set_abort(3, 1'b1);
        push(3, k + 7, AUTO ? 4'd2 : 4'd0, 1'b0, 1'b0, 1'b1, "u3_load2_after");
        step(1);
        set_abort(3, 1'b0);
        step(1);

        // PRESCALE=3, load 2 with pause held four cycles: done at accept+10.
        load(3, 4'd2, k);
        for (int j = 0; j <= 6; j++) push(3, k + j, 4'd2, 1'b0, 1'b1, 1'b0, "u3_pause_cnt2");
        for (int j = 7; j <= 9; j++) push(3, k + j, 4'd1, 1'b0, 1'b1, 1'b0, "u3_pause_cnt1");
        push(3, k + 10, AUTO ? 4'd2 : 4'd0, 1'b1, AUTO, !AUTO, "u3_pause_done");
        push_done(3, k + 10);
        push(3, k + 11, AUTO ? 4'd2 : 4'd0, 1'b0, 1'b0, 1'b1, "u3_pause_after");
        step(1);
        bus3.pause = 1'b1;
        step(4);
        bus3.pause = 1'b0;
        step(5);
        set_abort(3, 1'b1);
        step(1);
        set_abort(3, 1'b0);
        step(1);

        // Load 9, abort while count=3: count holds, no done; then load 0 gives an immediate done.
        load(1, 4'd9, k);
        for (int j = 0; j <= 6; j++) push(1, k + j, 4'(9 - j), 1'b0, 1'b1, 1'b0, "u1_load9");
        step(6);
        set_abort(1, 1'b1);
        step(1);
        set_abort(1, 1'b0);
        push(1, cyc, 4'd3, 1'b0, 1'b0, 1'b1, "u1_abort_hold");
        push(1, cyc + 1, 4'd3, 1'b0, 1'b0, 1'b1, "u1_abort_idle");
        step(1);
        load(1, 4'd0, k);
        push(1, k, 4'd0, 1'b1, 1'b0, 1'b1, "u1_load0_done");
        push_done(1, k);
        push(1, k + 1, 4'd0, 1'b0, 1'b0, 1'b1, "u1_load0_after");
        step(2);

        // Load 3: periodic 3,2,1,3,2,1 with reload, else 3,2,1,0 and idle.
        load(1, 4'd3, k);
        if (AUTO) begin
            for (int j = 0; j <= 6; j++) begin
                push(1, k + j, 4'(3 - (j % 3)), (j == 3 || j == 6), 1'b1, 1'b0, "u1_periodic");
            end
            push_done(1, k + 3);
            push_done(1, k + 6);
            push(1, k + 7, 4'd3, 1'b0, 1'b0, 1'b1, "u1_periodic_abort");
            step(6);
        end else begin
            push_run(1, k, 3, 1, "u1_oneshot3");
            push(1, k + 4, 4'd0, 1'b0, 1'b0, 1'b1, "u1_oneshot3_idle");
            step(3);
        end
        set_abort(1, 1'b1);
        step(1);
        set_abort(1, 1'b0);
        step(1);

        // Reset mid-run at count=4.
        load(1, 4'd9, k);
        for (int j = 0; j <= 5; j++) push(1, k + j, 4'(9 - j), 1'b0, 1'b1, 1'b0, "u1_prereset");
        step(5);
        reset = 1'b1;
        push(1, k + 6, 4'd0, 1'b0, 1'b0, 1'b1, "u1_midrun_reset");
        step(1);
        reset = 1'b0;
        step(3);

        check("scoreboard_drained", exp_q.size() + done1_q.size() + done3_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
